// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder: two half-adder cells and an OR
// joining their carries. Purely combinational.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic hs;
  logic hc0;
  logic hc1;

  assign hs   = a ^ b;
  assign hc0  = a & b;
  assign s    = hs ^ cin;
  assign hc1  = hs & cin;
  assign cout = hc0 | hc1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fa_cell and a carry flop,
// LSB first, parallel result with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           next;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [CW-1:0]    counter;
  logic             carry;
  logic             fa_s;
  logic             fa_c;
  logic             last;
  logic             load;
  logic             shift;

  fa_cell u_fa (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last = (counter == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // Illegal encoding falls through to IDLE.
  always_comb begin
    next = IDLE;
    unique case (state)
      IDLE:    next = start ? RUN : IDLE;
      RUN:     next = last ? DONE : RUN;
      DONE:    next = start ? RUN : IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state)
      IDLE: begin
        load = start;
      end
      RUN: begin
        shift = 1'b1;
        busy  = 1'b1;
      end
      DONE: begin
        load = start;
        done = 1'b1;
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa     <= '0;
      opb     <= '0;
      sum     <= '0;
      counter <= '0;
      carry   <= 1'b0;
      cout    <= 1'b0;
    end else if (load) begin
      opa     <= a;
      opb     <= b;
      sum     <= '0;
      counter <= '0;
      carry   <= 1'b0;
      cout    <= 1'b0;
    end else if (shift) begin
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      sum   <= {fa_s, sum[WIDTH-1:1]};
      carry <= fa_c;
      if (last) begin
        cout <= fa_c;
      end else begin
        counter <= counter + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder against
// a plain-arithmetic reference sum.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = DEF_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;
  logic [W:0] last_res = '0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_add(logic [W-1:0] x, logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_op(logic [W-1:0] x, logic [W-1:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    chk("accept", 32'({busy, done}), 32'b10);
  endtask

  task automatic finish_op(logic [W-1:0] x, logic [W-1:0] y, int spur);
    logic [W:0] r;
    r = ref_add(x, y);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      start = (k == spur);
      if (k == spur) begin
        a = '1;
        b = '1;
      end
      @(posedge clk);
      #1;
      if (k < W) chk("run", 32'({busy, done}), 32'b10);
    end
    start = 1'b0;
    chk("done", 32'({busy, done}), 32'b01);
    chk("result", 32'({cout, sum}), 32'(r));
    last_res = r;
  endtask

  task automatic idle_step();
    @(posedge clk);
    #1;
    chk("drop", 32'({busy, done}), 32'b00);
    chk("hold", 32'({cout, sum}), 32'(last_res));
  endtask

  task automatic op(logic [W-1:0] x, logic [W-1:0] y, int spur);
    start_op(x, y);
    finish_op(x, y, spur);
    idle_step();
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;

    repeat (2) @(posedge clk);
    #1;
    chk("reset", 32'({busy, done, cout, sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op(8'h00, 8'h00, -1);
    op(8'h5A, 8'h25, -1);
    op(8'hFF, 8'h01, -1);
    op(8'hFF, 8'hFF, -1);
    op(8'h10, 8'h20, 3);

    // Reset in the middle of a run discards the result.
    start_op(8'h0F, 8'h01);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst", 32'({busy, done, cout, sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk);
      #1;
      chk("nodone", 32'({busy, done, cout, sum}), 32'd0);
    end
    op(8'h0F, 8'h01, -1);

    // Back-to-back: second start held during the DONE cycle.
    start_op(8'h03, 8'h04);
    finish_op(8'h03, 8'h04, -1);
    start_op(8'h80, 8'h80);
    finish_op(8'h80, 8'h80, -1);
    idle_step();

    for (int n = 0; n < 40; n++) begin
      x = W'($urandom);
      y = W'($urandom);
      start_op(x, y);
      finish_op(x, y, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, W - 1)));
      if ($urandom_range(0, 1) == 0) idle_step();
    end
    idle_step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
